fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 9 +
 rtl/fetch_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and a
// synchronous-read instruction memory (slave).
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (output imem_addr, input  imem_rdata);
   modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one in-flight fetch slot matching the
// one-cycle memory read latency, and the IF/ID pipeline register with decode
// field breakout. Redirects squash both wrong-path slots; bubbles always carry
// a canonical NOP so downstream control never sees a stale instruction.
module fetch_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [31:0]  branch_target,
   fetch_stage_if.master imem,
   output logic         id_valid,
   output logic [31:0]  id_pc,
   output logic [31:0]  id_instr,
   output logic [6:0]   opcode,
   output logic [2:0]   func3,
   output logic [6:0]   func7,
   output logic [4:0]   rs1,
   output logic [4:0]   rs2,
   output logic [4:0]   rd,
   output logic [31:0]  fetch_count
);

   // addi x0,x0,0: carried by every bubble in IF/ID
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [31:0] r_pc;
   logic [31:0] r_fetch_pc;
   logic        r_fetch_valid;
   logic        r_id_valid;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_instr;
   logic [31:0] r_fetch_count;

   logic [31:0] w_pc_nxt;
   logic [31:0] w_fetch_pc_nxt;
   logic        w_fetch_valid_nxt;
   logic        w_id_valid_nxt;
   logic [31:0] w_id_pc_nxt;
   logic [31:0] w_id_instr_nxt;
   logic [31:0] w_fetch_count_nxt;
   logic [31:0] w_target;

   // Redirect target is always word aligned; low bits are dropped.
   assign w_target = branch_target & 32'hFFFF_FFFC;

   // Next-state selection: branch redirect beats stall, stall beats advance.
   always_comb begin
      w_pc_nxt          = r_pc;
      w_fetch_pc_nxt    = r_fetch_pc;
      w_fetch_valid_nxt = r_fetch_valid;
      w_id_valid_nxt    = r_id_valid;
      w_id_pc_nxt       = r_id_pc;
      w_id_instr_nxt    = r_id_instr;
      w_fetch_count_nxt = r_fetch_count;
      if (branch_taken) begin
         w_pc_nxt          = w_target;
         w_fetch_valid_nxt = 1'b0;
         w_id_valid_nxt    = 1'b0;
         w_id_instr_nxt    = NOP_INSTR;
         w_id_pc_nxt       = 32'd0;
      end else if (stall) begin
         w_pc_nxt          = r_pc;
         w_fetch_valid_nxt = r_fetch_valid;
      end else begin
         w_pc_nxt          = r_pc + 32'd4;
         w_fetch_pc_nxt    = r_pc;
         w_fetch_valid_nxt = 1'b1;
         w_id_valid_nxt    = r_fetch_valid;
         w_id_pc_nxt       = r_fetch_pc;
         if (r_fetch_valid) begin
            w_id_instr_nxt    = imem.imem_rdata;
            w_fetch_count_nxt = r_fetch_count + 32'd1;
         end else begin
            w_id_instr_nxt    = NOP_INSTR;
            w_fetch_count_nxt = r_fetch_count;
         end
      end
   end

   // State registers with synchronous reset overriding all other requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= 32'd0;
         r_fetch_pc    <= 32'd0;
         r_fetch_valid <= 1'b0;
         r_id_valid    <= 1'b0;
         r_id_pc       <= 32'd0;
         r_id_instr    <= NOP_INSTR;
         r_fetch_count <= 32'd0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_fetch_pc    <= w_fetch_pc_nxt;
         r_fetch_valid <= w_fetch_valid_nxt;
         r_id_valid    <= w_id_valid_nxt;
         r_id_pc       <= w_id_pc_nxt;
         r_id_instr    <= w_id_instr_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   assign imem.imem_addr = r_pc;
   assign id_valid       = r_id_valid;
   assign id_pc          = r_id_pc;
   assign id_instr       = r_id_instr;
   assign fetch_count    = r_fetch_count;

   assign opcode = r_id_instr[6:0];
   assign func3  = r_id_instr[14:12];
   assign func7  = r_id_instr[31:25];
   assign rs1    = r_id_instr[19:15];
   assign rs2    = r_id_instr[24:20];
   assign rd     = r_id_instr[11:7];

endmodule
